// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants and sizing helpers for the two-port RAM
package ram_pkg;

  localparam int INIT_HEX = 0;
  localparam int INIT_BIN = 1;

  // Never returns less than 1 so a depth-1 RAM still gets a legal index width
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int lanes(input int dw);
    return (dw + 7) / 8;
  endfunction

endpackage

// File: rtl/ram_resp_reg.sv
// rtl/ram_resp_reg.sv - registered response slot with hold and grant logic for one port
module ram_resp_reg
  import ram_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req,
  input  logic          i_rready,
  input  logic [DW-1:0] i_rdata,
  input  logic          i_err,
  output logic          o_gnt,
  output logic          o_xfer,
  output logic          o_rvalid,
  output logic [DW-1:0] o_rdata,
  output logic          o_err
);

  logic          r_rvalid;
  logic [DW-1:0] r_rdata;
  logic          r_err;
  logic          w_gnt;
  logic          w_xfer;

  assign w_gnt  = !r_rvalid || i_rready;
  assign w_xfer = i_req && w_gnt;

  // A new transfer overwrites the slot; otherwise a consumed response just drops valid
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else if (w_xfer) begin
      r_rvalid <= 1'b1;
      r_rdata  <= i_rdata;
      r_err    <= i_err;
    end else if (i_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign o_gnt    = w_gnt;
  assign o_xfer   = w_xfer;
  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_err    = r_err;

endmodule

// File: rtl/ram_gen_2p.sv
// rtl/ram_gen_2p.sv - two-port synchronous RAM, port A read/write with byte lanes, port B read-only
module ram_gen_2p
  import ram_pkg::*;
#(
  parameter int    DP        = 512,
  parameter int    DW        = 32,
  parameter int    MW        = lanes(DW),
  parameter int    AW        = 32,
  parameter string INIT_FILE = "",
  parameter int    INIT_FMT  = INIT_BIN,
  parameter bit    BYPASS    = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic [MW-1:0] a_sel,
  output logic          a_gnt,
  output logic          a_rvalid,
  input  logic          a_rready,
  output logic [DW-1:0] a_rdata,
  output logic          a_err,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  output logic          b_gnt,
  output logic          b_rvalid,
  input  logic          b_rready,
  output logic [DW-1:0] b_rdata,
  output logic          b_err
);

  localparam int IW = clog2(DP);

  logic [DW-1:0] r_mem [DP];

  logic          w_a_xfer;
  logic          w_b_xfer;
  logic          w_a_in;
  logic          w_b_in;
  logic [IW-1:0] w_a_idx;
  logic [IW-1:0] w_b_idx;
  logic [DW-1:0] w_a_old;
  logic [DW-1:0] w_b_old;
  logic [DW-1:0] w_a_merged;
  logic          w_a_wr;
  logic          w_b_col;
  logic [DW-1:0] w_a_rdata_nx;
  logic [DW-1:0] w_b_rdata_nx;

  initial begin
    for (int i = 0; i < DP; i++) r_mem[i] = '0;
  end

  // Full-width compare so high address bits can never alias onto a valid word
  assign w_a_in  = a_addr < AW'(DP);
  assign w_b_in  = b_addr < AW'(DP);
  assign w_a_idx = a_addr[IW-1:0];
  assign w_b_idx = b_addr[IW-1:0];
  assign w_a_old = r_mem[w_a_idx];
  assign w_b_old = r_mem[w_b_idx];

  // The top lane may be narrower than 8 bits when DW is not a multiple of 8
  for (genvar g = 0; g < MW; g++) begin : g_lane
    localparam int LO = 8 * g;
    localparam int HI = (8 * g + 7 > DW - 1) ? DW - 1 : 8 * g + 7;
    assign w_a_merged[HI:LO] = a_sel[g] ? a_wdata[HI:LO] : w_a_old[HI:LO];
  end

  assign w_a_wr = w_a_xfer && a_we && w_a_in;

  always_ff @(posedge clk) begin
    if (rst && w_a_wr) r_mem[w_a_idx] <= w_a_merged;
  end

  assign w_b_col = BYPASS && w_a_wr && w_b_xfer && w_b_in && (a_addr == b_addr);

  assign w_a_rdata_nx = (a_we || !w_a_in) ? '0 : w_a_old;
  assign w_b_rdata_nx = !w_b_in ? '0 : (w_b_col ? w_a_merged : w_b_old);

  ram_resp_reg #(.DW(DW)) u_resp_a (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_req    (a_req),
    .i_rready (a_rready),
    .i_rdata  (w_a_rdata_nx),
    .i_err    (!w_a_in),
    .o_gnt    (a_gnt),
    .o_xfer   (w_a_xfer),
    .o_rvalid (a_rvalid),
    .o_rdata  (a_rdata),
    .o_err    (a_err)
  );

  ram_resp_reg #(.DW(DW)) u_resp_b (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_req    (b_req),
    .i_rready (b_rready),
    .i_rdata  (w_b_rdata_nx),
    .i_err    (!w_b_in),
    .o_gnt    (b_gnt),
    .o_xfer   (w_b_xfer),
    .o_rvalid (b_rvalid),
    .o_rdata  (b_rdata),
    .o_err    (b_err)
  );

endmodule
